// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
//   Shared types and constants for the memory/writeback boundary stage.
//   - mem_wb_state_t : dcache wait FSM states
//   - wb_bundle_t    : registered writeback payload {valid, en, rd, data}
//   - REG_ZERO       : architectural zero register index (never written)
//   The bundle is sized for the widest supported build (64-bit datapath,
//   5-bit register index); the stage truncates to its own parameters.
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

  localparam int unsigned WB_XLEN  = 64;
  localparam int unsigned WB_REG_W = 5;

  localparam logic [WB_REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WAIT_ST = 2'd2
  } mem_wb_state_t;

  typedef struct packed {
    logic                valid;
    logic                en;
    logic [WB_REG_W-1:0] rd;
    logic [WB_XLEN-1:0]  data;
  } wb_bundle_t;

  function automatic logic is_wait_state(input mem_wb_state_t s);
    return (s == WAIT_LD) || (s == WAIT_ST);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
//   Bundles the memory-stage request, the dcache completion pulses and the
//   writeback/stall outputs of mem_wb_stage.
//   Handshake: an instruction is offered while in_valid=1. It is consumed on
//   the rising edge where in_valid=1 and stall_mem=0. While stall_mem=1 the
//   producer must hold every in_* signal stable; dropping in_valid while
//   stalled is a flush and the instruction is discarded. dcache_valid and
//   write_done are single-cycle completion pulses with no back-pressure.
//   Modports:
//     master : memory stage / dcache side (drives in_*, dcache_valid,
//              write_done; observes stall_mem and wb_*)
//     slave  : mem_wb_stage
// ---------------------------------------------------------------------------
interface mem_wb_stage_if #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
);

  logic                  in_valid;
  logic                  in_is_load;
  logic                  in_is_store;
  logic                  in_writes_rd;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [XLEN-1:0]       in_ex_result;
  logic [XLEN-1:0]       in_mem_rdata;
  logic                  dcache_valid;
  logic                  write_done;

  logic                  stall_mem;
  logic                  wb_valid;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  modport master (
    output in_valid, in_is_load, in_is_store, in_writes_rd, in_rd,
           in_ex_result, in_mem_rdata, dcache_valid, write_done,
    input  stall_mem, wb_valid, wb_en, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_writes_rd, in_rd,
           in_ex_result, in_mem_rdata, dcache_valid, write_done,
    output stall_mem, wb_valid, wb_en, wb_rd, wb_data
  );

endinterface

// File: rtl/mem_wb_stage_watchdog.sv
// ---------------------------------------------------------------------------
// mem_wb_watchdog
//   Counts consecutive cycles the stage spends waiting on the dcache and
//   raises a sticky flag once the count reaches TIMEOUT_CYCLES.
//   Ports:
//     clk_i      clock
//     rst_i      asynchronous active-high reset
//     in_wait_i  stage FSM is in a wait state this cycle
//     timeout_o  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_wait_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // The counter sits at zero outside wait states, so entry always starts
  // from zero. It saturates at LIMIT to avoid wrapping on a hung dcache.
  always_comb begin
    cnt_d = '0;
    if (in_wait_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | (cnt_d == LIMIT);
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory/writeback pipeline boundary. Accepts the memory-stage instruction,
//   holds the pipeline while a dcache load or store is outstanding, and
//   registers the register-file write plus retirement strobe.
//   Ports:
//     clk           clock
//     reset         asynchronous active-high reset
//     bus           mem_wb_stage_if.slave: in_* request, dcache_valid,
//                   write_done, stall_mem (combinational), wb_* (registered)
//     instret       retired-instruction counter (wraps)
//     stall_cycles  count of cycles with stall_mem high (wraps)
//     mem_timeout   sticky dcache watchdog flag
//     dbg_state     current FSM state
//   Build option: define MEM_WB_TIMEOUT_EN to enable the dcache watchdog;
//   without it mem_timeout is constant 0.
// ---------------------------------------------------------------------------
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned REG_ADDR_W     = 5,
  parameter int unsigned CNT_W          = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  mem_wb_stage_if.slave      bus,
  output logic [CNT_W-1:0]   instret,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               mem_timeout,
  output mem_wb_state_t      dbg_state
);

  if ((XLEN > WB_XLEN) || (REG_ADDR_W > WB_REG_W) || (TIMEOUT_CYCLES < 1))
  begin : g_bad_cfg
    $error("mem_wb_stage: unsupported parameter combination");
  end

  mem_wb_state_t    state_q;
  wb_bundle_t       wb_q;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic            sel_load;
  logic            sel_store;
  logic            done;
  logic            stall;
  logic            retire;
  logic [XLEN-1:0] ret_data;

  // While waiting, the operation type is taken from the state so only the
  // matching completion pulse can end the wait. In IDLE a load+store
  // encoding is treated as a load.
  always_comb begin
    sel_load  = 1'b0;
    sel_store = 1'b0;
    case (state_q)
      WAIT_LD: sel_load  = 1'b1;
      WAIT_ST: sel_store = 1'b1;
      default: begin
        sel_load  = bus.in_is_load;
        sel_store = bus.in_is_store & ~bus.in_is_load;
      end
    endcase
  end

  always_comb begin
    done = 1'b1;
    if (sel_load) begin
      done = bus.dcache_valid;
    end else if (sel_store) begin
      done = bus.write_done;
    end
  end

  assign stall  = bus.in_valid & (sel_load | sel_store) & ~done;
  assign retire = bus.in_valid & done;

  always_comb begin
    ret_data = bus.in_ex_result;
    if (sel_load) begin
      ret_data = bus.in_mem_rdata;
    end else if (sel_store) begin
      ret_data = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wb_q           <= '0;
      instret_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      // Flush (in_valid low) or completion both return to IDLE.
      case (state_q)
        IDLE: begin
          if (stall) begin
            state_q <= sel_load ? WAIT_LD : WAIT_ST;
          end
        end
        WAIT_LD, WAIT_ST: begin
          if (!stall) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      wb_q.valid <= retire;
      wb_q.en    <= retire & bus.in_writes_rd & ~sel_store &
                    (bus.in_rd != REG_ADDR_W'(REG_ZERO));
      if (retire) begin
        wb_q.rd   <= WB_REG_W'(bus.in_rd);
        wb_q.data <= WB_XLEN'(ret_data);
        instret_q <= instret_q + CNT_W'(1);
      end

      if (stall) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_mem = stall;
  assign bus.wb_valid  = wb_q.valid;
  assign bus.wb_en     = wb_q.en;
  assign bus.wb_rd     = wb_q.rd[REG_ADDR_W-1:0];
  assign bus.wb_data   = wb_q.data[XLEN-1:0];
  assign instret       = instret_q;
  assign stall_cycles  = stall_cycles_q;
  assign dbg_state     = state_q;

`ifdef MEM_WB_TIMEOUT_EN
  mem_wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (reset),
    .in_wait_i (is_wait_state(state_q)),
    .timeout_o (mem_timeout)
  );
`else
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. Inputs change 1 time unit after a
//   rising edge; combinational stall_mem is checked 1 unit after that, and
//   registered outputs are checked 1 unit after the edge that produces them.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

`ifdef MEM_WB_TIMEOUT_EN
  localparam int unsigned TO_CYCLES  = 8;
  localparam logic        TO_EXPECT  = 1'b1;
`else
  localparam int unsigned TO_CYCLES  = 1024;
  localparam logic        TO_EXPECT  = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [63:0]   instret;
  logic [63:0]   stall_cycles;
  logic          mem_timeout;
  mem_wb_state_t dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_wb_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

  mem_wb_stage #(
    .XLEN           (64),
    .REG_ADDR_W     (5),
    .CNT_W          (64),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .instret      (instret),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic wr, input logic [4:0] rd,
                       input logic [63:0] ex, input logic [63:0] rdata,
                       input logic dv, input logic wd);
    bus.in_valid     = v;
    bus.in_is_load   = ld;
    bus.in_is_store  = st;
    bus.in_writes_rd = wr;
    bus.in_rd        = rd;
    bus.in_ex_result = ex;
    bus.in_mem_rdata = rdata;
    bus.dcache_valid = dv;
    bus.write_done   = wd;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic en,
                        input logic [4:0] rd, input logic [63:0] data);
    chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(v));
    chk({tag, ".wb_en"},    64'(bus.wb_en),    64'(en));
    chk({tag, ".wb_rd"},    64'(bus.wb_rd),    64'(rd));
    chk({tag, ".wb_data"},  bus.wb_data,       data);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0);
    step();
    step();
    chk_wb("reset", 0, 0, 5'd0, 64'h0);
    chk("reset.instret", instret, 64'd0);
    chk("reset.stall_cycles", stall_cycles, 64'd0);
    chk("reset.timeout", 64'(mem_timeout), 64'd0);
    chk("reset.state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;

    // ALU op, rd=5
    step();
    drive(1, 0, 0, 1, 5'd5, 64'h1234, 64'hdead, 0, 0);
    chk("alu.stall", 64'(bus.stall_mem), 64'd0);
    step();
    chk_wb("alu", 1, 1, 5'd5, 64'h1234);
    chk("alu.instret", instret, 64'd1);

    // load miss, rd=7, data returns on the 4th cycle
    drive(1, 1, 0, 1, 5'd7, 64'h99, 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
    chk("ldmiss.stall0", 64'(bus.stall_mem), 64'd1);
    step();
    chk("ldmiss.state", 64'(dbg_state), 64'(WAIT_LD));
    chk("ldmiss.stall1", 64'(bus.stall_mem), 64'd1);
    chk("ldmiss.wbv_wait", 64'(bus.wb_valid), 64'd0);
    step();
    drive(1, 1, 0, 1, 5'd7, 64'h99, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    chk("ldmiss.wrongdone", 64'(bus.stall_mem), 64'd1);
    step();
    drive(1, 1, 0, 1, 5'd7, 64'h99, 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
    chk("ldmiss.stall_done", 64'(bus.stall_mem), 64'd0);
    chk("ldmiss.stall_cycles", stall_cycles, 64'd3);
    step();
    chk_wb("ldmiss", 1, 1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ldmiss.instret", instret, 64'd2);
    chk("ldmiss.state_idle", 64'(dbg_state), 64'(IDLE));

    // store rd=3, write_done after 2 stall cycles; stray dcache_valid ignored
    drive(1, 0, 1, 1, 5'd3, 64'hAAAA, 64'hBBBB, 0, 0);
    chk("st.stall0", 64'(bus.stall_mem), 64'd1);
    step();
    chk("st.state", 64'(dbg_state), 64'(WAIT_ST));
    drive(1, 0, 1, 1, 5'd3, 64'hAAAA, 64'hBBBB, 1, 0);
    chk("st.wrongdone", 64'(bus.stall_mem), 64'd1);
    step();
    chk("st.wbv_wait", 64'(bus.wb_valid), 64'd0);
    drive(1, 0, 1, 1, 5'd3, 64'hAAAA, 64'hBBBB, 0, 1);
    chk("st.stall_done", 64'(bus.stall_mem), 64'd0);
    step();
    chk_wb("st", 1, 0, 5'd3, 64'h0);
    chk("st.instret", instret, 64'd3);
    chk("st.stall_cycles", stall_cycles, 64'd5);

    // load to x0 with immediate hit, back-to-back with the store
    drive(1, 1, 0, 1, 5'd0, 64'h1, 64'h55, 1, 0);
    chk("ldx0.stall", 64'(bus.stall_mem), 64'd0);
    step();
    chk_wb("ldx0", 1, 0, 5'd0, 64'h55);
    chk("ldx0.instret", instret, 64'd4);

    // bubble with stray completion pulses: no retirement, wb_rd/data hold
    drive(0, 1, 0, 1, 5'd9, 64'h77, 64'h66, 1, 1);
    chk("bubble.stall", 64'(bus.stall_mem), 64'd0);
    step();
    chk_wb("bubble", 0, 0, 5'd0, 64'h55);
    chk("bubble.instret", instret, 64'd4);

    // load+store encoding behaves as a load: write_done alone does not finish
    drive(1, 1, 1, 1, 5'd4, 64'h10, 64'h20, 0, 1);
    chk("both.stall_st", 64'(bus.stall_mem), 64'd1);
    drive(1, 1, 1, 1, 5'd4, 64'h10, 64'h20, 1, 0);
    chk("both.stall_ld", 64'(bus.stall_mem), 64'd0);
    step();
    chk("both.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("both.wb_data", bus.wb_data, 64'h20);
    chk("both.instret", instret, 64'd5);

    // flush while waiting
    drive(1, 1, 0, 1, 5'd8, 64'h0, 64'h30, 0, 0);
    step();
    chk("flush.state", 64'(dbg_state), 64'(WAIT_LD));
    drive(0, 1, 0, 1, 5'd8, 64'h0, 64'h30, 0, 0);
    chk("flush.stall", 64'(bus.stall_mem), 64'd0);
    step();
    chk("flush.state_idle", 64'(dbg_state), 64'(IDLE));
    chk_wb("flush", 0, 0, 5'd4, 64'h20);
    chk("flush.instret", instret, 64'd5);
    chk("flush.stall_cycles", stall_cycles, 64'd6);

    // reset in the middle of a load wait
    drive(1, 1, 0, 1, 5'd11, 64'h0, 64'h40, 0, 0);
    step();
    step();
    chk("rstmid.state_pre", 64'(dbg_state), 64'(WAIT_LD));
    reset = 1'b1;
    #1;
    chk_wb("rstmid", 0, 0, 5'd0, 64'h0);
    chk("rstmid.instret", instret, 64'd0);
    chk("rstmid.stall_cycles", stall_cycles, 64'd0);
    chk("rstmid.state", 64'(dbg_state), 64'(IDLE));
    drive(0, 1, 0, 1, 5'd11, 64'h0, 64'h40, 1, 0);
    reset = 1'b0;
    step();
    chk("rstmid.late_done", 64'(bus.wb_valid), 64'd0);
    chk("rstmid.late_instret", instret, 64'd0);

    // long wait: watchdog fires only when compiled in
    drive(1, 1, 0, 1, 5'd9, 64'h0, 64'h50, 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk("wd.early", 64'(mem_timeout), 64'd0);
    for (int i = 0; i < 8; i++) step();
    chk("wd.state", 64'(dbg_state), 64'(WAIT_LD));
    chk("wd.stall", 64'(bus.stall_mem), 64'd1);
    chk("wd.stall_cycles", stall_cycles, 64'd12);
    chk("wd.timeout", 64'(mem_timeout), 64'(TO_EXPECT));
    drive(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0);
    step();
    step();
    chk("wd.sticky", 64'(mem_timeout), 64'(TO_EXPECT));
    chk("wd.no_retire", 64'(bus.wb_valid), 64'd0);
    chk("wd.instret", instret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Downstream neighbour of the memory stage: the memory/writeback boundary of the in-order pipeline.
- Accepts the memory-stage instruction, ALU result and extended load data.
- Tracks outstanding dcache loads/stores with an FSM and stalls the pipeline until the dcache completes.
- Registers the architectural register-file write and retirement, with performance counters.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDR_W, 5, register index width.
- CNT_W, 64, width of performance counters.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with MEM_WB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  non-bubble instruction present in memory stage.
- in_is_load  input  1  instruction is a load.
- in_is_store  input  1  instruction is a store.
- in_writes_rd  input  1  instruction writes rd.
- in_rd  input  REG_ADDR_W  destination register.
- in_ex_result  input  XLEN  ALU/EX result.
- in_mem_rdata  input  XLEN  sign/zero-extended load data from memory stage.
- dcache_valid  input  1  load-complete pulse.
- write_done  input  1  store-complete pulse.
- stall_mem  output  1  hold all upstream stages this cycle (combinational).
- wb_valid  output  1  registered retirement strobe.
- wb_en  output  1  registered register-file write enable.
- wb_rd  output  REG_ADDR_W  registered write index.
- wb_data  output  XLEN  registered write data.
- instret  output  CNT_W  retired-instruction count.
- stall_cycles  output  CNT_W  cycles with stall_mem high.
- mem_timeout  output  1  sticky watchdog flag (0 when feature absent).

Behaviour:
- Reset (async, active-high): state=IDLE. wb_valid, wb_en, wb_rd, wb_data, instret, stall_cycles and mem_timeout all 0. Reset mid-wait aborts the op with no retirement.
- FSM states: IDLE, WAIT_LD, WAIT_ST.
- Completion ("done"):
  - Load: dcache_valid.
  - Store: write_done.
  - Non-memory op: immediate.
- IDLE:
  - !in_valid: no action; wb_valid=0 next edge. Stray done pulses are ignored.
  - in_valid, non-memory op: retire at next edge with wb_data=in_ex_result.
  - in_valid, load with dcache_valid this cycle: retire at next edge with wb_data=in_mem_rdata; stall_mem=0.
  - in_valid, load without done: stall_mem=1; go to WAIT_LD.
  - in_valid, store with write_done this cycle: retire, no stall.
  - in_valid, store without done: stall_mem=1; go to WAIT_ST.
  - in_is_load and in_is_store both high: treat as load.
- WAIT_LD / WAIT_ST:
  - stall_mem=1 until the done cycle. On the done cycle stall_mem=0, retire at that edge, go to IDLE.
  - Inputs are held stable by upstream while stalled.
  - in_valid dropping while waiting means flush: go to IDLE, no retirement, stall_mem=0.
  - The wrong-type done pulse is ignored.
- stall_mem = in_valid & mem_op & !done, in every state.
- Retire edge:
  - wb_valid=1 for exactly one cycle per instruction.
  - wb_rd=in_rd.
  - wb_en = in_writes_rd & !in_is_store & (in_rd!=0).
  - wb_data=0 for stores.
  - instret increments by 1.
- Non-retire edges: wb_valid=0, wb_en=0; wb_rd and wb_data hold.
- Back-to-back: a new instruction is accepted every cycle when no stall. Throughput is 1/cycle; writeback latency is 1 edge after the done cycle.
- Counters: stall_cycles increments each cycle stall_mem=1. Both counters wrap modulo 2^CNT_W.

Optional Feature:
- MEM_WB_TIMEOUT_EN defined:
  - Wait counter clears on entry to WAIT_LD/WAIT_ST and increments each cycle in a wait state.
  - Reaching TIMEOUT_CYCLES sets mem_timeout (sticky until reset).
  - FSM behaviour is unchanged.
- Undefined: no counter logic; mem_timeout tied to 0.

Decomposition:
- Shared package:
  - mem_wb_state_t enum {IDLE, WAIT_LD, WAIT_ST}.
  - wb_bundle_t struct {valid, en, rd, data}.
  - Constant REG_ZERO=0.
- Sub-module mem_wb_watchdog (wait counter + sticky flag), instantiated only under MEM_WB_TIMEOUT_EN.
- All other logic inline.

Test Plan:
- Non-memory op: ALU op rd=5, in_ex_result=0x1234 → next edge wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234; instret=1.
- Load miss: load rd=7, dcache_valid pulses 3 cycles later with in_mem_rdata=0xFFFF_FFFF_FFFF_FF80 → stall_mem high 3 cycles, stall_cycles=3, then wb_data=0xFFFF_FFFF_FFFF_FF80, wb_rd=7.
- Store with write_done after 2 cycles → stall_mem high 2 cycles, then wb_valid=1, wb_en=0, wb_data=0.
- Load to rd=0 with immediate hit → wb_valid=1, wb_en=0.
- Reset asserted during WAIT_LD → all outputs and counters 0 immediately, state IDLE. A later dcache_valid with in_valid=0 causes no retirement.
- With MEM_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, a load with no dcache_valid → mem_timeout=1 after 8 wait cycles and stays 1.
